// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and header field layout for the source arbiter
//
// Holds the arbiter FSM state enum, the source count, the header field
// positions and two small index helpers used by router_src_arb.

package router_pkg;

    localparam int NUM_SRC  = 3;
    localparam int PTR_W    = 2;

    // Header byte layout: [DATA_W-1:LEN_LSB] payload length, [ADDR_W-1:ADDR_LSB] destination
    localparam int ADDR_LSB = 0;
    localparam int ADDR_W   = 2;
    localparam int LEN_LSB  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_PARITY
    } state_t;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_SRC-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (oh[i]) begin
                idx = PTR_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NUM_SRC - 1)) ? '0 : idx + PTR_W'(1);
    endfunction

endpackage

// File: rtl/router_rr_pick.sv
// rtl/router_rr_pick.sv - combinational round-robin one-hot picker
//
// Ports:
//   req  - request vector, one bit per source
//   ptr  - index of the source with highest priority this round
//   gnt  - one-hot grant: first requester at or after ptr, wrapping; zero if no request

module router_rr_pick #(
    parameter int NUM_SRC = router_pkg::NUM_SRC,
    parameter int PTR_W   = router_pkg::PTR_W
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] gnt
);

    logic found;

    // Outer loop walks priority order (offset from ptr); inner loop finds the
    // source sitting at that offset, keeping every index a loop constant.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!found && req[i] && (((int'(ptr) + k) % NUM_SRC) == i)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/router_src_arb.sv
// rtl/router_src_arb.sv - round-robin arbiter multiplexing packet sources onto one router input
//
// Ports:
//   clock          - sole clock, rising edge
//   reset          - synchronous, active-high
//   src_pkt_valid  - per-source packet valid (high on header/payload, low on parity)
//   src_data       - per-source byte, source n at [n*DATA_W +: DATA_W]
//   src_busy       - per-source stall back to the sources
//   rtr_busy       - router stall
//   pkt_valid      - packet valid to the router
//   data_in        - byte to the router
//   grant          - one-hot owner of the router input, zero when idle
//   len_err        - one-cycle pulse on a packet-length violation

module router_src_arb #(
    parameter int DATA_W  = 8,
    parameter int NUM_SRC = router_pkg::NUM_SRC
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_pkt_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_busy,
    input  logic                      rtr_busy,
    output logic                      pkt_valid,
    output logic [DATA_W-1:0]         data_in,
    output logic [NUM_SRC-1:0]        grant,
    output logic                      len_err
);

    import router_pkg::*;

    localparam int LEN_W = DATA_W - LEN_LSB;

    state_t               state, state_nxt;
    logic [NUM_SRC-1:0]   grant_q, grant_nxt, pick;
    logic [PTR_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic [LEN_W-1:0]     cnt, cnt_nxt;
    logic [DATA_W-1:0]    g_data;
    logic                 g_valid;
    logic                 xfer;
    logic                 exit_pkt;
    logic                 len_viol;

    router_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req (src_pkt_valid),
        .ptr (rr_ptr),
        .gnt (pick)
    );

    // Granted source's byte; grant_q is zero in IDLE so this is zero there too.
    always_comb begin
        g_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q[i]) begin
                g_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign g_valid = |(src_pkt_valid & grant_q);
    assign xfer    = (state != ST_IDLE) && !rtr_busy;

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_q;
        rr_ptr_nxt = rr_ptr;
        cnt_nxt    = cnt;
        exit_pkt   = 1'b0;
        len_viol   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|src_pkt_valid) begin
                    grant_nxt = pick;
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                // A granted source that has not yet raised valid simply holds us here.
                if (xfer && g_valid) begin
                    cnt_nxt   = g_data[DATA_W-1:LEN_LSB];
                    state_nxt = (cnt_nxt != '0) ? ST_PAYLOAD : ST_PARITY;
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    if (g_valid) begin
                        cnt_nxt = cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            state_nxt = ST_PARITY;
                        end
                    end else begin
                        // Source ended early: this byte is its parity, packet is short.
                        len_viol = 1'b1;
                        exit_pkt = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (xfer) begin
                    // Valid still high at the parity slot means the packet ran long.
                    len_viol = g_valid;
                    exit_pkt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (exit_pkt) begin
            state_nxt  = ST_IDLE;
            grant_nxt  = '0;
            rr_ptr_nxt = next_ptr(onehot_to_idx(grant_q));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            rr_ptr  <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            rr_ptr  <= rr_ptr_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // Outputs are also forced while reset is asserted so a mid-packet reset
    // never leaks a stale byte or error pulse in the reset cycle itself.
    assign grant     = reset ? '0 : grant_q;
    assign pkt_valid = !reset && g_valid && ((state == ST_HDR) || (state == ST_PAYLOAD));
    assign data_in   = reset ? '0 : g_data;
    assign src_busy  = (reset || (state == ST_IDLE)) ? '1 : (~grant_q | {NUM_SRC{rtr_busy}});
    assign len_err   = !reset && len_viol;

endmodule

// File: tb/tb_router_src_arb.sv
// tb/tb_router_src_arb.sv - directed self-checking bench for router_src_arb

module tb_router_src_arb;

    localparam int DATA_W  = 8;
    localparam int NUM_SRC = 3;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_SRC-1:0]        src_pkt_valid = '0;
    logic [NUM_SRC*DATA_W-1:0] src_data = '0;
    logic [NUM_SRC-1:0]        src_busy;
    logic                      rtr_busy = 1'b0;
    logic                      pkt_valid;
    logic [DATA_W-1:0]         data_in;
    logic [NUM_SRC-1:0]        grant;
    logic                      len_err;

    int n_cmp = 0;
    int n_bad = 0;

    router_src_arb #(
        .DATA_W  (DATA_W),
        .NUM_SRC (NUM_SRC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .src_pkt_valid (src_pkt_valid),
        .src_data      (src_data),
        .src_busy      (src_busy),
        .rtr_busy      (rtr_busy),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .grant         (grant),
        .len_err       (len_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] g, input logic pv,
                              input logic [7:0] d, input logic [2:0] b, input logic le);
        check({tag, ".grant"},     32'(grant),     32'(g));
        check({tag, ".pkt_valid"}, 32'(pkt_valid), 32'(pv));
        check({tag, ".data_in"},   32'(data_in),   32'(d));
        check({tag, ".src_busy"},  32'(src_busy),  32'(b));
        check({tag, ".len_err"},   32'(len_err),   32'(le));
    endtask

    // Returns 1 ns after the rising edge, away from the sampling edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input int n, input logic v, input logic [7:0] b);
        src_pkt_valid[n]              = v;
        src_data[n*DATA_W +: DATA_W]  = b;
        #1;
    endtask

    logic [2:0] rr_exp [4];

    initial begin
        rr_exp[0] = 3'b001;
        rr_exp[1] = 3'b010;
        rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001;

        // Reset with all sources requesting: nothing may be granted.
        src_pkt_valid = 3'b111;
        step();
        step();
        expect_out("rst", 3'b000, 1'b0, 8'h00, 3'b111, 1'b0);
        reset = 1'b0;
        src_pkt_valid = '0;
        step();
        expect_out("idle", 3'b000, 1'b0, 8'h00, 3'b111, 1'b0);

        // Source 1: header 0x0D (len 3, addr 1), 3 payload bytes, parity.
        present(1, 1'b1, 8'h0D);
        check("t034.pre_grant", 32'(grant), 32'd0);
        step();                         expect_out("t034.hdr", 3'b010, 1'b1, 8'h0D, 3'b101, 1'b0);
        step(); present(1, 1'b1, 8'hA1); expect_out("t034.p1",  3'b010, 1'b1, 8'hA1, 3'b101, 1'b0);
        step(); present(1, 1'b1, 8'hA2); expect_out("t034.p2",  3'b010, 1'b1, 8'hA2, 3'b101, 1'b0);
        step(); present(1, 1'b1, 8'hA3); expect_out("t034.p3",  3'b010, 1'b1, 8'hA3, 3'b101, 1'b0);
        step(); present(1, 1'b0, 8'h5A); expect_out("t034.par", 3'b010, 1'b0, 8'h5A, 3'b101, 1'b0);
        step(); present(1, 1'b0, 8'h00); expect_out("t034.end", 3'b000, 1'b0, 8'h00, 3'b111, 1'b0);

        // Source 0: header 0x0C (len 3); router stalls 4 cycles mid-payload
        // while source 2 raises its request and must wait.
        present(0, 1'b1, 8'h0C);
        step();                         expect_out("t035.hdr", 3'b001, 1'b1, 8'h0C, 3'b110, 1'b0);
        step(); present(0, 1'b1, 8'hB1); expect_out("t035.p1",  3'b001, 1'b1, 8'hB1, 3'b110, 1'b0);
        step(); present(0, 1'b1, 8'hB2);
        present(2, 1'b1, 8'h10);
        rtr_busy = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            expect_out("t035.stall", 3'b001, 1'b1, 8'hB2, 3'b111, 1'b0);
            step();
        end
        rtr_busy = 1'b0;
        #1;
        expect_out("t035.p2",  3'b001, 1'b1, 8'hB2, 3'b110, 1'b0);
        step(); present(0, 1'b1, 8'hB3); expect_out("t035.p3",  3'b001, 1'b1, 8'hB3, 3'b110, 1'b0);
        step(); present(0, 1'b0, 8'h6C); expect_out("t035.par", 3'b001, 1'b0, 8'h6C, 3'b110, 1'b0);
        step(); present(0, 1'b0, 8'h00); expect_out("t035.end", 3'b000, 1'b0, 8'h00, 3'b111, 1'b0);

        // Source 2 (waiting since the stall): header 0x10 (len 4), drops after 2 bytes.
        step();                         expect_out("t036.hdr", 3'b100, 1'b1, 8'h10, 3'b011, 1'b0);
        step(); present(2, 1'b1, 8'hC1); expect_out("t036.p1",  3'b100, 1'b1, 8'hC1, 3'b011, 1'b0);
        step(); present(2, 1'b1, 8'hC2); expect_out("t036.p2",  3'b100, 1'b1, 8'hC2, 3'b011, 1'b0);
        step(); present(2, 1'b0, 8'hE7); expect_out("t036.drop", 3'b100, 1'b0, 8'hE7, 3'b011, 1'b1);
        step(); present(2, 1'b0, 8'h00); expect_out("t036.end", 3'b000, 1'b0, 8'h00, 3'b111, 1'b0);

        // Source 0: header 0x02 (len 0, addr 2) -> header then parity.
        present(0, 1'b1, 8'h02);
        step();                         expect_out("t037.hdr", 3'b001, 1'b1, 8'h02, 3'b110, 1'b0);
        step(); present(0, 1'b0, 8'h99); expect_out("t037.par", 3'b001, 1'b0, 8'h99, 3'b110, 1'b0);
        step(); present(0, 1'b0, 8'h00); expect_out("t037.end", 3'b000, 1'b0, 8'h00, 3'b111, 1'b0);

        // Source 1: len 0 but valid still high in the parity slot -> len_err.
        present(1, 1'b1, 8'h00);
        step();                         expect_out("long.hdr", 3'b010, 1'b1, 8'h00, 3'b101, 1'b0);
        step(); present(1, 1'b1, 8'h77); expect_out("long.par", 3'b010, 1'b0, 8'h77, 3'b101, 1'b1);
        step(); present(1, 1'b0, 8'h00); expect_out("long.end", 3'b000, 1'b0, 8'h00, 3'b111, 1'b0);

        // Reset, then all three request len-0 packets continuously.
        reset = 1'b1;
        src_pkt_valid = 3'b111;
        src_data = '0;
        step();
        reset = 1'b0;
        #1;
        expect_out("t033.rst", 3'b000, 1'b0, 8'h00, 3'b111, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("t033.grant%0d", k), 32'(grant), 32'(rr_exp[k]));
            step();
            step();
        end
        src_pkt_valid = '0;
        #1;

        // Source 0 packet reset mid-payload; the next search must start at source 0.
        present(0, 1'b1, 8'h0C);
        step();                         check("t038.grant", 32'(grant), 32'(3'b001));
        step(); present(0, 1'b1, 8'hD1); expect_out("t038.pay", 3'b001, 1'b1, 8'hD1, 3'b110, 1'b0);
        reset = 1'b1;
        #1;
        expect_out("t038.in_rst", 3'b000, 1'b0, 8'h00, 3'b111, 1'b0);
        step();
        expect_out("t038.after", 3'b000, 1'b0, 8'h00, 3'b111, 1'b0);
        src_pkt_valid = 3'b111;
        src_data = '0;
        reset = 1'b0;
        #1;
        step();
        check("t038.first_grant", 32'(grant), 32'(3'b001));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/router_src_arb.md
ROUTER_SRC_ARB -- requirements
Module: router_src_arb

Interface
REQ-001 Parameter DATA_W, default 8, byte width; bits [DATA_W-1:2] of a header are payload length, bits [1:0] are destination address.
REQ-002 Parameter NUM_SRC, default 3, number of source ports; fixed at 3 in this release.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 src_pkt_valid  input  NUM_SRC  per-source packet valid; high on header and payload bytes, low on the parity byte.
REQ-006 src_data  input  NUM_SRC*DATA_W  per-source byte; source n occupies bits [n*DATA_W +: DATA_W].
REQ-007 src_busy  output  NUM_SRC  per-source stall; the source holds its byte while high.
REQ-008 rtr_busy  input  1  router stall; no byte is accepted while high.
REQ-009 pkt_valid  output  1  packet valid to the router.
REQ-010 data_in  output  DATA_W  byte to the router.
REQ-011 grant  output  NUM_SRC  one-hot owner of the router input; all zero when idle.
REQ-012 len_err  output  1  one-cycle pulse on a packet-length violation.

Function
REQ-013 A byte transfers only in a cycle where the FSM is not IDLE and rtr_busy is 0; this is the "xfer" event.
REQ-014 FSM states: IDLE, HDR, PAYLOAD, PARITY.
REQ-015 IDLE: if any src_pkt_valid is high, register a one-hot grant chosen round-robin starting at rr_ptr, then go to HDR next cycle (1-cycle grant latency); otherwise stay in IDLE.
REQ-016 HDR: on xfer with src_pkt_valid[g] high, load cnt = header[DATA_W-1:2]; go to PAYLOAD if cnt is nonzero, else PARITY.
REQ-017 PAYLOAD: on xfer with src_pkt_valid[g] high, decrement cnt; go to PARITY when cnt reaches 0.
REQ-018 PAYLOAD, early drop: if src_pkt_valid[g] is low with cnt nonzero, pulse len_err, forward the byte as parity on xfer, then go to IDLE.
REQ-019 PARITY: on xfer, forward the byte with pkt_valid 0 and go to IDLE; if src_pkt_valid[g] is high here, also pulse len_err.
REQ-020 On every exit to IDLE: rr_ptr becomes (g+1) mod NUM_SRC and grant clears.
REQ-021 pkt_valid = src_pkt_valid[g] in HDR/PAYLOAD; forced 0 in IDLE and PARITY.
REQ-022 data_in = src_data of the granted source, combinational; all zero in IDLE.
REQ-023 src_busy[n] = 1 if n is not the granted source or the FSM is IDLE; for the granted source it equals rtr_busy.
REQ-024 A source raising valid mid-packet of another source waits; it is never granted before the current packet exits to IDLE.
REQ-025 HDR with src_pkt_valid[g] low: stay in HDR, no timeout.
REQ-026 rtr_busy high in any state: hold state, cnt and grant unchanged.
REQ-027 Payload length 0 gives the byte sequence header then parity (2 bytes); the maximum is 2^(DATA_W-2)-1 payload bytes.

Reset
REQ-028 When reset is high: FSM goes to IDLE, rr_ptr=0, cnt=0, grant=0, len_err=0, pkt_valid=0, data_in=0, src_busy all 1.
REQ-029 Reset mid-packet aborts the packet without a len_err pulse; the first grant after reset starts search at source 0.

Structure
REQ-030 Shared package router_pkg shall hold the FSM state enum, NUM_SRC, and the header length/address field positions.
REQ-031 Round-robin selection shall be a sub-module router_rr_pick (req, ptr -> one-hot gnt, combinational).
REQ-032 Target size: 150-300 lines of RTL.

Verification
REQ-033 src_pkt_valid=3'b111 held after reset -> grants go 001, 010, 100, 001 in order, one per completed packet.
REQ-034 Source 1 sends header 8'h0D (len 3, addr 1), 3 payload bytes, then parity -> router sees 5 bytes, pkt_valid=1,1,1,1,0, then IDLE.
REQ-035 rtr_busy held high for 4 cycles mid-payload -> src_busy[g]=1, data_in stable, cnt unchanged, no byte lost.
REQ-036 Header 8'h10 (len 4), source drops valid after 2 payload bytes -> len_err pulses once, FSM goes to IDLE after that byte.
REQ-037 Header 8'h02 (len 0) -> header then parity only; pkt_valid=1 then 0.
REQ-038 Reset asserted in PAYLOAD -> next cycle IDLE, all outputs at reset values, len_err=0.
